// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - cache-to-memory block request/response bundle
interface mem_responder_if #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_BYTES = 16
);
    logic                       req_valid;
    logic                       write;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [BLOCK_BYTES*8-1:0]   data_out;
    logic                       cache_miss;
    logic                       ready;
    logic [BLOCK_BYTES*8-1:0]   data_in;

    modport master (
        output req_valid, write, addr, data_out, cache_miss,
        input  ready, data_in
    );

    modport slave (
        input  req_valid, write, addr, data_out, cache_miss,
        output ready, data_in
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency block memory responder with access statistics
module mem_responder #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 64,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_responder_if.slave      bus,
    output logic                init_done,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [31:0]         miss_count
);
    localparam int DW = BLOCK_BYTES * 8;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t         state, next_state;
    logic [IW-1:0]  clr_idx;
    logic [IW-1:0]  lat_idx;
    logic           lat_write;
    logic [DW-1:0]  lat_data;
    logic [CW-1:0]  lat_cnt;
    logic           ready_q;
    logic [DW-1:0]  data_q;
    logic [DW-1:0]  mem [DEPTH];

    logic           accept;
    logic           access;
    logic           clr_last;

    assign bus.ready   = ready_q;
    assign bus.data_in = data_q;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        access     = 1'b0;
        clr_last   = (clr_idx == IW'(DEPTH - 1));
        case (state)
            ST_INIT: if (clr_last) next_state = ST_IDLE;
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (lat_cnt == '0) begin
                    access     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: if (!bus.req_valid) next_state = ST_IDLE;
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_INIT;
        else      state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_idx    <= '0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_data   <= '0;
            lat_cnt    <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            init_done  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            miss_count <= '0;
        end else begin
            // ready follows the state being entered, so it is a flop with no input-to-output path
            ready_q <= (next_state == ST_IDLE) || (next_state == ST_DONE);
            if (state == ST_INIT) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_last) init_done <= 1'b1;
            end
            if (accept) begin
                lat_idx   <= bus.addr[IW-1:0];
                lat_write <= bus.write;
                lat_data  <= bus.data_out;
                lat_cnt   <= CW'(LATENCY - 1);
                if (bus.write) wr_count <= wr_count + 32'd1;
                else           rd_count <= rd_count + 32'd1;
                if (bus.cache_miss) miss_count <= miss_count + 32'd1;
            end
            if (state == ST_BUSY && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
            if (access && !lat_write) data_q <= mem[lat_idx];
        end
    end

    // Storage has no reset of its own; INIT sweeps it, and a reset edge suppresses any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT)         mem[clr_idx] <= '0;
            else if (access && lat_write) mem[lat_idx] <= lat_data;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;
    localparam int AW  = 28;
    localparam int BB  = 16;
    localparam int DEP = 64;
    localparam int LAT = 3;

    typedef struct {
        string        name;
        int           low;
        logic [127:0] data;
        logic [31:0]  rd;
        logic [31:0]  wr;
        logic [31:0]  miss;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [31:0] rd_count, wr_count, miss_count;

    mem_responder_if #(.ADDR_WIDTH(AW), .BLOCK_BYTES(BB)) bus ();

    mem_responder #(.ADDR_WIDTH(AW), .BLOCK_BYTES(BB), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .init_done  (init_done),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [127:0] model_mem [DEP];
    logic [127:0] m_data;
    logic [31:0]  m_rd, m_wr, m_miss;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) model_mem[i] = '0;
        m_data = '0;
        m_rd   = '0;
        m_wr   = '0;
        m_miss = '0;
    endtask

    task automatic push_init();
        exp_t e;
        e.name = "init";
        e.low  = DEP;
        e.data = '0;
        e.rd   = '0;
        e.wr   = '0;
        e.miss = '0;
        q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per rising edge of ready, stability checks while ready stays high
    int   low_cnt   = 0;
    bit   prev_rdy  = 1'b0;
    bit   have_hold = 1'b0;
    exp_t hold;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            low_cnt  = 0;
            prev_rdy = 1'b0;
        end else if (bus.ready !== 1'b1) begin
            low_cnt++;
            prev_rdy = 1'b0;
        end else if (!prev_rdy) begin
            prev_rdy = 1'b1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got response with empty scoreboard");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_low_cycles"}, 128'(low_cnt), 128'(e.low));
                chk({e.name, "_data_in"},   bus.data_in, e.data);
                chk({e.name, "_rd_count"},  128'(rd_count), 128'(e.rd));
                chk({e.name, "_wr_count"},  128'(wr_count), 128'(e.wr));
                chk({e.name, "_miss_count"}, 128'(miss_count), 128'(e.miss));
                chk({e.name, "_init_done"}, 128'(init_done), 128'(1));
                hold      = e;
                have_hold = 1'b1;
            end
            low_cnt = 0;
        end else if (have_hold) begin
            chk({hold.name, "_hold_data"}, bus.data_in, hold.data);
            chk({hold.name, "_hold_rd"},   128'(rd_count), 128'(hold.rd));
            chk({hold.name, "_hold_wr"},   128'(wr_count), 128'(hold.wr));
            chk({hold.name, "_hold_miss"}, 128'(miss_count), 128'(hold.miss));
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready still %b expected 1", name, bus.ready);
        end
    endtask

    task automatic do_req(input string name, input logic wr, input logic [AW-1:0] a,
                          input logic [127:0] d, input logic miss, input int hold_cycles,
                          input bit toggle_miss);
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.write      = wr;
        bus.addr       = a;
        bus.data_out   = d;
        bus.cache_miss = miss;
        if (wr) begin
            model_mem[a % DEP] = d;
            m_wr++;
        end else begin
            m_data = model_mem[a % DEP];
            m_rd++;
        end
        if (miss) m_miss++;
        e.name = name;
        e.low  = LAT;
        e.data = m_data;
        e.rd   = m_rd;
        e.wr   = m_wr;
        e.miss = m_miss;
        q.push_back(e);
        @(posedge clk); #1;
        if (hold_cycles == 0) bus.req_valid = 1'b0;
        bus.addr     = ~a;
        bus.data_out = ~d;
        bus.write    = ~wr;
        for (int n = 0; n < 50 && bus.ready !== 1'b1; n++) begin
            if (toggle_miss) bus.cache_miss = ~bus.cache_miss;
            @(posedge clk); #1;
        end
        wait_ready(name);
        for (int i = 0; i < hold_cycles; i++) begin
            bus.addr = bus.addr + 28'd1;
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.cache_miss = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_ready"},     128'(bus.ready), 128'(0));
        chk({name, "_init_done"}, 128'(init_done), 128'(0));
        chk({name, "_data_in"},   bus.data_in, '0);
        chk({name, "_rd_count"},  128'(rd_count), 128'(0));
        chk({name, "_wr_count"},  128'(wr_count), 128'(0));
        chk({name, "_miss_count"}, 128'(miss_count), 128'(0));
    endtask

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] DA = {16{8'hA5}};
    localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [127:0] D3 = 128'h0F0F0F0F_F0F0F0F0_12121212_34343434;

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.write      = 1'b0;
        bus.addr       = '0;
        bus.data_out   = '0;
        bus.cache_miss = 1'b0;
        model_reset();
        push_init();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_init_ready",     128'(bus.ready), 128'(0));
        chk("mid_init_init_done", 128'(init_done), 128'(0));
        @(posedge clk); #1;
        wait_ready("init");
        @(posedge clk); #1;

        do_req("rd_1234",  1'b0, 28'h1234, '0, 1'b0, 0, 1'b0);
        do_req("wr_5",     1'b1, 28'd5,    D1, 1'b0, 0, 1'b0);
        do_req("rd_5",     1'b0, 28'd5,    '0, 1'b0, 0, 1'b0);
        do_req("wr_69",    1'b1, 28'd69,   DA, 1'b0, 0, 1'b0);
        do_req("rd_5_alias", 1'b0, 28'd5,  '0, 1'b0, 0, 1'b0);
        do_req("rd_69_hold", 1'b0, 28'd69, '0, 1'b0, 5, 1'b0);
        do_req("miss_wr_10", 1'b1, 28'd10, D2, 1'b1, 0, 1'b1);
        do_req("miss_rd_10", 1'b0, 28'd10, '0, 1'b0, 0, 1'b1);
        do_req("miss_rd_3",  1'b0, 28'd3,  '0, 1'b1, 0, 1'b1);
        do_req("miss_wr_63", 1'b1, 28'd63, D3, 1'b0, 0, 1'b1);
        do_req("miss_rd_127", 1'b0, 28'd127, '0, 1'b1, 0, 1'b1);
        chk("miss_total", 128'(miss_count), 128'(3));

        bus.req_valid  = 1'b1;
        bus.write      = 1'b1;
        bus.addr       = 28'd7;
        bus.data_out   = D2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        q.delete();
        have_hold = 1'b0;
        push_init();
        @(posedge clk);
        @(negedge clk);
        reset_checks("busy_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        wait_ready("reinit");
        @(posedge clk); #1;
        do_req("rd_7_after_reset", 1'b0, 28'd7, '0, 1'b0, 0, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
